crt_parser: RTL and testbench
=============================

# crt_parser

Streaming parser for `.CRT` cartridge images delivered byte-serially by the loader during a download. It validates the file and CHIP signatures, and extracts the header fields: hardware type, EXROM and GAME. For every CHIP packet it emits one bank record, and it writes each packet's ROM payload into the SDRAM cartridge region at 8 KiB-aligned offsets. It is the producer of the `cart_*` bank-record bus consumed by the cartridge mapper.

## Interface
Parameters:
- `ROM_BASE`, 24'h100000: SDRAM byte address of cartridge region offset 0.
- `ROM_SPAN`, 24'h100000: region size in bytes; payload beyond it is an error.

Ports:
- `clk32`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  download window active.
- `ioctl_wr`  in  1  one-cycle strobe; `ioctl_data` valid.
- `ioctl_data`  in  8  file byte, file order.
- `ioctl_wait`  out  1  back-pressure; upstream must not strobe while high.
- `mem_addr`  out  24  SDRAM write address.
- `mem_data`  out  8  SDRAM write data.
- `mem_wr`  out  1  write request, level, held until `mem_ack`.
- `mem_ack`  in  1  one-cycle completion of `mem_wr`.
- `cart_id`  out  16  hardware type, file offset 0x16-0x17, big-endian.
- `cart_exrom`  out  8  file offset 0x18.
- `cart_game`  out  8  file offset 0x19.
- `cart_bank_type`  out  8  CHIP offset 0x09 (low byte of chip type).
- `cart_bank_num`  out  16  CHIP offset 0x0A-0x0B, big-endian.
- `cart_bank_laddr`  out  16  CHIP offset 0x0C-0x0D, big-endian.
- `cart_bank_size`  out  16  CHIP offset 0x0E-0x0F, big-endian.
- `cart_bank_raddr`  out  24  region offset of this packet's payload; 8 KiB aligned.
- `cart_bank_wr`  out  1  one-cycle pulse per bank record.
- `cart_loading`  out  1  high while a download is being parsed.
- `cart_attached`  out  1  last download parsed successfully.
- `crt_err`  out  1  last download was rejected.

## Operation
State machine states: IDLE, HDR, CHIP_HDR, DATA, SKIP, ERR.

- **IDLE**
  - A rising `ioctl_download` clears `cart_attached`, `crt_err` and the offset pointer `wptr`, sets `cart_loading`, and enters HDR with byte counter 0.
- **HDR**
  - Bytes 0x00-0x0F must equal ASCII "C64 CARTRIDGE   ". Any mismatch goes to ERR.
  - Bytes 0x10-0x13 form the header length `hlen` (32-bit, big-endian).
  - Bytes 0x16-0x19 load `cart_id`, `cart_exrom` and `cart_game`.
  - The header ends after max(`hlen`, 0x40) bytes; the state then moves to CHIP_HDR with counter 0.
- **CHIP_HDR**
  - Bytes 0-3 must be "CHIP"; a mismatch goes to ERR.
  - Bytes 4-7 form the packet length `plen` (32-bit, big-endian).
  - Bytes 8-15 load the bank fields.
  - After byte 15:
    - If `plen < 16 + size`, go to ERR.
    - Otherwise `cart_bank_raddr <= wptr` and `cart_bank_wr` pulses.
    - If `size == 0`, go to SKIP (or to CHIP_HDR when `plen == 16`); otherwise go to DATA.
- **DATA**
  - Each byte is written to `ROM_BASE + cart_bank_raddr + i`.
  - If `cart_bank_raddr + size > ROM_SPAN`, the transition into DATA goes to ERR instead, after the `cart_bank_wr` pulse.
  - After byte `size-1`:
    - `wptr <= cart_bank_raddr + ((size + 0x1FFF) & ~0x1FFF)`. This rounds up, so a 4 KiB chip consumes one 8 KiB slot and a 16 KiB chip consumes two.
    - Go to SKIP if `plen > 16 + size`, else to CHIP_HDR.
- **SKIP**
  - Discards `plen - 16 - size` bytes, then returns to CHIP_HDR.
- **ERR**
  - Discards all bytes until the download ends. `crt_err` is set at entry.
- **End of download** (falling `ioctl_download`):
  - `cart_loading` goes to 0 and the state returns to IDLE.
  - `cart_attached` is set only if all of these hold: not ERR, at least one bank record was emitted, and the file ended in CHIP_HDR at counter 0 or inside DATA/SKIP.
  - A truncated payload is accepted. Unwritten bytes are left unchanged.
  - Ending inside HDR, or in CHIP_HDR with counter 1-15, sets `crt_err` and leaves `cart_attached` at 0.

## Timing
- Reset values:
  - State IDLE.
  - `ioctl_wait`, `mem_wr`, `cart_bank_wr`, `cart_loading`, `cart_attached`, `crt_err` all 0.
  - All field registers and `mem_addr`/`mem_data` 0.
- Reset mid-download aborts with the same values. A subsequent rising `ioctl_download` is required to restart.
- Header and CHIP-header bytes are consumed in the strobe cycle; `ioctl_wait` stays 0 for them.
- DATA bytes:
  - The cycle after the strobe, `mem_wr=1` and `ioctl_wait=1`, with address and data registered.
  - Both hold until `mem_ack`. The cycle after `mem_ack`, both drop.
  - Minimum per-byte cost is 3 cycles.
- A strobe arriving while `ioctl_wait=1` is dropped, and the counter does not advance.
- Bank record timing:
  - `cart_bank_wr` is high exactly one cycle, the cycle after byte 15 of the CHIP header.
  - All `cart_bank_*` fields are stable in that cycle and hold until the next record.
- Field stability: `cart_id`, `cart_exrom` and `cart_game` are stable from byte 0x19 onward.
- End-of-download handling:
  - A strobe coincident with the falling `ioctl_download` is processed first. End-of-file evaluation happens the next cycle, or after `mem_ack` if a write is pending.
  - `cart_loading` falls and `cart_attached` is set in the same cycle.
- Counters are 32-bit. `wptr` and the `raddr` arithmetic are 24-bit; overflow past `ROM_SPAN` is an error, never wrap-around.

## Test plan
- **Valid 8K cart.** Header with `hlen=0x40`, type 0, EXROM 0, GAME 1; one CHIP with `plen=0x2010`, bank 0, laddr 0x8000, size 0x2000.
  - One `cart_bank_wr` with `raddr=0`.
  - 8192 writes to 0x100000-0x101FFF.
  - `cart_attached=1`, `cart_id=0`, `cart_exrom=0`, `cart_game=1`.
- **Multi-packet 16K + 4K.** Chips of size 0x4000, then 0x1000.
  - Bank records with `raddr` 0x0000 and 0x4000.
  - Last write address is 0x104FFF.
- **Bad signature.** Byte 3 = 'X'.
  - `crt_err=1`, no `cart_bank_wr`, no `mem_wr`, `cart_attached=0`.
- **Header and packet padding.** `hlen=0x50` and `plen=0x2020`.
  - 16 padding bytes are skipped in each place.
  - Second packet payload starts exactly at `raddr` 0x2000.
- **Back-pressure.** `mem_ack` delayed by 5 cycles, plus a stray `ioctl_wr` while `ioctl_wait=1`.
  - The stray byte is dropped.
  - The memory image matches the file payload.
- **Reset and truncation.**
  - `reset` asserted mid-DATA: all outputs return to 0; a fresh download then parses correctly.
  - File cut at CHIP-header byte 7: `crt_err=1`, `cart_attached=0`.

Source files
------------

// File: rtl/crt_parser.sv
// rtl/crt_parser.sv - streaming .CRT image parser: header/CHIP validation, bank records, payload writes to SDRAM
module crt_parser #(
  parameter logic [23:0] ROM_BASE = 24'h100000,
  parameter logic [23:0] ROM_SPAN = 24'h100000
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic [15:0] cart_id,
  output logic [7:0]  cart_exrom,
  output logic [7:0]  cart_game,
  output logic [7:0]  cart_bank_type,
  output logic [15:0] cart_bank_num,
  output logic [15:0] cart_bank_laddr,
  output logic [15:0] cart_bank_size,
  output logic [23:0] cart_bank_raddr,
  output logic        cart_bank_wr,
  output logic        cart_loading,
  output logic        cart_attached,
  output logic        crt_err
);
  typedef enum logic [2:0] {IDLE, HDR, CHIP_HDR, DATA, SKIP, ERR} state_t;

  localparam logic [127:0] FILE_SIG = "C64 CARTRIDGE   ";
  localparam logic [31:0]  CHIP_SIG = "CHIP";

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, hlen_q, hlen_d, plen_q, plen_d;
  logic [23:0] wptr_q, wptr_d, raddr_q, raddr_d, mem_addr_q, mem_addr_d;
  logic [15:0] id_q, id_d, bnum_q, bnum_d, laddr_q, laddr_d, bsize_q, bsize_d;
  logic [7:0]  exrom_q, exrom_d, game_q, game_d, btype_q, btype_d, mem_data_q, mem_data_d;
  logic        bank_wr_q, bank_wr_d, loading_q, loading_d, attached_q, attached_d;
  logic        err_q, err_d, mem_wr_q, mem_wr_d, dl_q, dl_d, eof_q, eof_d, banks_q, banks_d;

  logic [31:0] hdr_end, need_len, pay_len, skip_len;
  logic [15:0] size_full;
  logic [24:0] end_addr;
  logic [23:0] size_rnd;
  logic [7:0]  sig_byte, chip_byte;
  logic        accept, eof_ok;

  assign hdr_end   = (hlen_q < 32'h40) ? 32'h40 : hlen_q;
  assign size_full = {bsize_q[7:0], ioctl_data};
  assign need_len  = {16'd0, size_full} + 32'd16;
  assign end_addr  = {1'b0, wptr_q} + {9'd0, size_full};
  assign pay_len   = {16'd0, bsize_q} + 32'd16;
  assign skip_len  = plen_q - pay_len;
  // Payload slots are 8 KiB granular, so a short chip still consumes a whole slot.
  assign size_rnd  = ({8'd0, bsize_q} + 24'h001FFF) & 24'hFFE000;
  assign sig_byte  = FILE_SIG[{4'd15 - cnt_q[3:0], 3'b000} +: 8];
  assign chip_byte = CHIP_SIG[{2'd3 - cnt_q[1:0], 3'b000} +: 8];
  assign accept    = ioctl_wr && !mem_wr_q && !eof_q;
  assign eof_ok    = (state_q != ERR) && banks_q &&
                     ((state_q == CHIP_HDR && cnt_q == 32'd0) || state_q == DATA || state_q == SKIP);

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;       hlen_d = hlen_q;       plen_d = plen_q;
    wptr_d = wptr_q;     raddr_d = raddr_q;   mem_addr_d = mem_addr_q; mem_data_d = mem_data_q;
    id_d = id_q;         exrom_d = exrom_q;   game_d = game_q;       btype_d = btype_q;
    bnum_d = bnum_q;     laddr_d = laddr_q;   bsize_d = bsize_q;
    loading_d = loading_q; attached_d = attached_q; err_d = err_q;
    mem_wr_d = mem_wr_q; eof_d = eof_q;       banks_d = banks_q;
    bank_wr_d = 1'b0;
    dl_d = ioctl_download;
    if (mem_wr_q && mem_ack) mem_wr_d = 1'b0;

    case (state_q)
      IDLE: if (!dl_q && ioctl_download) begin
        attached_d = 1'b0; err_d = 1'b0; wptr_d = 24'd0; banks_d = 1'b0;
        loading_d = 1'b1; state_d = HDR; cnt_d = 32'd0; hlen_d = 32'd0;
      end
      HDR: if (accept) begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q < 32'd16 && ioctl_data != sig_byte) state_d = ERR;
        else begin
          case (cnt_q)
            32'h10, 32'h11, 32'h12, 32'h13: hlen_d = {hlen_q[23:0], ioctl_data};
            32'h16: id_d[15:8] = ioctl_data;
            32'h17: id_d[7:0]  = ioctl_data;
            32'h18: exrom_d    = ioctl_data;
            32'h19: game_d     = ioctl_data;
            default: ;
          endcase
          if (cnt_q == hdr_end - 32'd1) begin
            state_d = CHIP_HDR; cnt_d = 32'd0;
          end
        end
      end
      CHIP_HDR: if (accept) begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q < 32'd4 && ioctl_data != chip_byte) state_d = ERR;
        else begin
          case (cnt_q)
            32'd4, 32'd5, 32'd6, 32'd7: plen_d = {plen_q[23:0], ioctl_data};
            32'd9:  btype_d = ioctl_data;
            32'd10, 32'd11: bnum_d  = {bnum_q[7:0], ioctl_data};
            32'd12, 32'd13: laddr_d = {laddr_q[7:0], ioctl_data};
            32'd14, 32'd15: bsize_d = size_full;
            default: ;
          endcase
          if (cnt_q == 32'd15) begin
            cnt_d = 32'd0;
            if (plen_q < need_len) state_d = ERR;
            else begin
              raddr_d = wptr_q; bank_wr_d = 1'b1; banks_d = 1'b1;
              if (end_addr > {1'b0, ROM_SPAN}) state_d = ERR;
              else if (size_full == 16'd0) state_d = (plen_q == 32'd16) ? CHIP_HDR : SKIP;
              else state_d = DATA;
            end
          end
        end
      end
      DATA: if (accept) begin
        mem_wr_d = 1'b1;
        mem_addr_d = ROM_BASE + raddr_q + cnt_q[23:0];
        mem_data_d = ioctl_data;
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == {16'd0, bsize_q} - 32'd1) begin
          wptr_d = raddr_q + size_rnd; cnt_d = 32'd0;
          state_d = (plen_q > pay_len) ? SKIP : CHIP_HDR;
        end
      end
      SKIP: if (accept) begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == skip_len - 32'd1) begin
          state_d = CHIP_HDR; cnt_d = 32'd0;
        end
      end
      default: ;
    endcase

    if (state_d == ERR && state_q != ERR) err_d = 1'b1;
    if (state_q != IDLE && dl_q && !ioctl_download) eof_d = 1'b1;
    // The end-of-file verdict waits for any in-flight payload write to retire.
    if (eof_q && !mem_wr_q) begin
      eof_d = 1'b0; state_d = IDLE; loading_d = 1'b0;
      attached_d = eof_ok; err_d = !eof_ok;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= IDLE;     cnt_q <= 32'd0;    hlen_q <= 32'd0;     plen_q <= 32'd0;
      wptr_q <= 24'd0;     raddr_q <= 24'd0;  mem_addr_q <= 24'd0; mem_data_q <= 8'd0;
      id_q <= 16'd0;       exrom_q <= 8'd0;   game_q <= 8'd0;      btype_q <= 8'd0;
      bnum_q <= 16'd0;     laddr_q <= 16'd0;  bsize_q <= 16'd0;
      bank_wr_q <= 1'b0;   loading_q <= 1'b0; attached_q <= 1'b0;  err_q <= 1'b0;
      mem_wr_q <= 1'b0;    eof_q <= 1'b0;     banks_q <= 1'b0;
      dl_q <= 1'b1;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;    hlen_q <= hlen_d;    plen_q <= plen_d;
      wptr_q <= wptr_d;    raddr_q <= raddr_d; mem_addr_q <= mem_addr_d; mem_data_q <= mem_data_d;
      id_q <= id_d;        exrom_q <= exrom_d; game_q <= game_d;   btype_q <= btype_d;
      bnum_q <= bnum_d;    laddr_q <= laddr_d; bsize_q <= bsize_d;
      bank_wr_q <= bank_wr_d; loading_q <= loading_d; attached_q <= attached_d; err_q <= err_d;
      mem_wr_q <= mem_wr_d; eof_q <= eof_d;   banks_q <= banks_d;
      dl_q <= dl_d;
    end
  end

  assign ioctl_wait      = mem_wr_q;
  assign mem_wr          = mem_wr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_data        = mem_data_q;
  assign cart_id         = id_q;
  assign cart_exrom      = exrom_q;
  assign cart_game       = game_q;
  assign cart_bank_type  = btype_q;
  assign cart_bank_num   = bnum_q;
  assign cart_bank_laddr = laddr_q;
  assign cart_bank_size  = bsize_q;
  assign cart_bank_raddr = raddr_q;
  assign cart_bank_wr    = bank_wr_q;
  assign cart_loading    = loading_q;
  assign cart_attached   = attached_q;
  assign crt_err         = err_q;
endmodule

// File: tb/tb_crt_parser.sv
// tb/tb_crt_parser.sv - table-driven bench for crt_parser with a byte-checking SDRAM responder
module tb_crt_parser;
  localparam logic [23:0] ROM_BASE = 24'h100000;

  logic        clk32 = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, mem_ack = 1'b0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wait, mem_wr, cart_bank_wr, cart_loading, cart_attached, crt_err;
  logic [23:0] mem_addr, cart_bank_raddr;
  logic [7:0]  mem_data, cart_exrom, cart_game, cart_bank_type;
  logic [15:0] cart_id, cart_bank_num, cart_bank_laddr, cart_bank_size;

  crt_parser #(.ROM_BASE(ROM_BASE), .ROM_SPAN(24'h010000)) dut (
    .clk32(clk32), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_ack(mem_ack), .cart_id(cart_id), .cart_exrom(cart_exrom),
    .cart_game(cart_game), .cart_bank_type(cart_bank_type), .cart_bank_num(cart_bank_num),
    .cart_bank_laddr(cart_bank_laddr), .cart_bank_size(cart_bank_size),
    .cart_bank_raddr(cart_bank_raddr), .cart_bank_wr(cart_bank_wr), .cart_loading(cart_loading),
    .cart_attached(cart_attached), .crt_err(crt_err));

  always #5 clk32 = ~clk32;

  typedef struct packed {
    logic [31:0] hlen; logic [15:0] id; logic [7:0] exrom; logic [7:0] game;
    logic [1:0] nchips; logic [2:0][15:0] size; logic [2:0][15:0] pad;
    logic [31:0] bad_idx; logic [31:0] trunc; logic [3:0] ack_delay; logic stray;
    logic exp_att; logic exp_err; logic [1:0] exp_banks; logic [15:0] exp_writes;
    logic [2:0][23:0] exp_raddr;
  } vec_t;

  int checks = 0, failures = 0;
  int ack_delay = 0, ack_cnt = 0;
  bit stray_en = 1'b0;
  logic [7:0] file_q[$];
  vec_t tbl[12];

  int n_writes = 0, wbad = 0, n_banks = 0, pulse_bad = 0;
  logic [23:0] last_addr = 24'd0;
  logic bank_prev = 1'b0;
  logic [23:0] rec_raddr[64];
  logic [15:0] rec_num[64], rec_size[64], rec_laddr[64];
  logic [7:0]  rec_type[64];

  function automatic logic [7:0] byte_fn(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic vec_t mk(input int hl, idv, ex, gm, n, s0, s1, s2, p0, p1, p2,
                              input int bad, tr, ack, st, att, er, bk, wr, r0, r1, r2);
    vec_t v;
    v.hlen = hl; v.id = 16'(idv); v.exrom = 8'(ex); v.game = 8'(gm); v.nchips = 2'(n);
    v.size[0] = 16'(s0); v.size[1] = 16'(s1); v.size[2] = 16'(s2);
    v.pad[0] = 16'(p0); v.pad[1] = 16'(p1); v.pad[2] = 16'(p2);
    v.bad_idx = bad; v.trunc = tr; v.ack_delay = 4'(ack); v.stray = st[0];
    v.exp_att = att[0]; v.exp_err = er[0]; v.exp_banks = 2'(bk); v.exp_writes = 16'(wr);
    v.exp_raddr[0] = 24'(r0); v.exp_raddr[1] = 24'(r1); v.exp_raddr[2] = 24'(r2);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    logic [127:0] sig;
    int hl, plen, pad;
    sig = "C64 CARTRIDGE   ";
    file_q.delete();
    for (int i = 0; i < 16; i++) file_q.push_back(sig[127 - 8*i -: 8]);
    for (int i = 3; i >= 0; i--) file_q.push_back(v.hlen[8*i +: 8]);
    file_q.push_back(8'h01); file_q.push_back(8'h00);
    file_q.push_back(v.id[15:8]); file_q.push_back(v.id[7:0]);
    file_q.push_back(v.exrom); file_q.push_back(v.game);
    hl = (v.hlen < 32'h40) ? 32'h40 : int'(v.hlen);
    while (file_q.size() < hl) file_q.push_back(8'h00);
    for (int c = 0; c < int'(v.nchips); c++) begin
      pad = (v.pad[c] == 16'hFFFF) ? -1 : int'(v.pad[c]);
      plen = 16 + int'(v.size[c]) + pad;
      file_q.push_back("C"); file_q.push_back("H"); file_q.push_back("I"); file_q.push_back("P");
      for (int i = 3; i >= 0; i--) file_q.push_back(8'(plen >> (8*i)));
      file_q.push_back(8'h00); file_q.push_back(8'h00);
      file_q.push_back(8'h00); file_q.push_back(8'(c));
      file_q.push_back(8'h80); file_q.push_back(8'h00);
      file_q.push_back(v.size[c][15:8]); file_q.push_back(v.size[c][7:0]);
      for (int i = 0; i < int'(v.size[c]); i++)
        file_q.push_back(byte_fn(ROM_BASE + v.exp_raddr[c] + 24'(i)));
      for (int i = 0; i < pad; i++) file_q.push_back(8'h55);
    end
    if (v.bad_idx != 32'hFFFF_FFFF) file_q[v.bad_idx] = 8'h58;
    if (v.trunc != 0) while (file_q.size() > int'(v.trunc)) void'(file_q.pop_back());
  endtask

  // SDRAM responder: acknowledges each held write after ack_delay extra cycles.
  initial begin
    forever begin
      @(posedge clk32); #1;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_wr) begin
        if (ack_cnt >= ack_delay) begin mem_ack = 1'b1; ack_cnt = 0; end
        else ack_cnt++;
      end else ack_cnt = 0;
    end
  end

  always @(negedge clk32) begin
    if (mem_wr && mem_ack) begin
      n_writes++;
      if (mem_data !== byte_fn(mem_addr)) wbad++;
      last_addr = mem_addr;
    end
    if (cart_bank_wr) begin
      rec_raddr[n_banks % 64] = cart_bank_raddr; rec_num[n_banks % 64] = cart_bank_num;
      rec_size[n_banks % 64] = cart_bank_size; rec_laddr[n_banks % 64] = cart_bank_laddr;
      rec_type[n_banks % 64] = cart_bank_type;
      if (bank_prev) pulse_bad++;
      n_banks++;
    end
    bank_prev = cart_bank_wr;
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bit strayed = 1'b0;
    while (ioctl_wait === 1'b1 && guard < 200) begin
      if (stray_en && !strayed) begin ioctl_wr = 1'b1; ioctl_data = 8'hEE; strayed = 1'b1; end
      @(posedge clk32); #1;
      ioctl_wr = 1'b0;
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL wait_timeout actual=stuck required=ioctl_wait_low");
    end
    ioctl_wr = 1'b1; ioctl_data = b;
    @(posedge clk32); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk32); #1; end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ctl"}, {26'd0, ioctl_wait, mem_wr, cart_bank_wr, cart_loading, cart_attached, crt_err}, 32'd0);
    chk({p, "_mem"}, {mem_data, mem_addr}, 32'd0);
    chk({p, "_hdr"}, {cart_id, cart_exrom, cart_game}, 32'd0);
    chk({p, "_bank"}, {cart_bank_type, cart_bank_raddr}, 32'd0);
    chk({p, "_bank2"}, {cart_bank_num, cart_bank_size}, 32'd0);
    chk({p, "_bank3"}, {16'd0, cart_bank_laddr}, 32'd0);
  endtask

  task automatic run_entry(input int idx);
    vec_t v;
    int w0, wb0, b0, pb0, bank_bad, guard;
    string p;
    v = tbl[idx];
    p = $sformatf("v%0d", idx);
    build(v);
    ack_delay = int'(v.ack_delay); stray_en = v.stray;
    w0 = n_writes; wb0 = wbad; b0 = n_banks; pb0 = pulse_bad;
    ioctl_download = 1'b1;
    idle(1);
    foreach (file_q[i]) send_byte(file_q[i]);
    chk({p, "_loading_during"}, {31'd0, cart_loading}, 32'd1);
    ioctl_download = 1'b0;
    guard = 0;
    while (cart_loading === 1'b1 && guard < 50) begin idle(1); guard++; end
    chk({p, "_loading_end"}, {31'd0, cart_loading}, 32'd0);
    chk({p, "_attached"}, {31'd0, cart_attached}, {31'd0, v.exp_att});
    chk({p, "_err"}, {31'd0, crt_err}, {31'd0, v.exp_err});
    chk({p, "_banks"}, n_banks - b0, {30'd0, v.exp_banks});
    chk({p, "_writes"}, n_writes - w0, {16'd0, v.exp_writes});
    chk({p, "_wdata"}, wbad - wb0, 32'd0);
    chk({p, "_pulse"}, pulse_bad - pb0, 32'd0);
    bank_bad = 0;
    for (int k = 0; k < int'(v.exp_banks); k++) begin
      if (b0 + k < n_banks) begin
        if (rec_raddr[(b0 + k) % 64] !== v.exp_raddr[k] || rec_num[(b0 + k) % 64] !== 16'(k) ||
            rec_size[(b0 + k) % 64] !== v.size[k] || rec_laddr[(b0 + k) % 64] !== 16'h8000 ||
            rec_type[(b0 + k) % 64] !== 8'h00) bank_bad++;
      end
    end
    chk({p, "_bankf"}, bank_bad, 32'd0);
    if (v.exp_att) chk({p, "_fields"}, {cart_id, cart_exrom, cart_game}, {v.id, v.exrom, v.game});
    if (v.exp_writes != 0 && v.trunc == 0 && !v.exp_err)
      chk({p, "_last"}, {8'd0, last_addr},
          {8'd0, ROM_BASE + v.exp_raddr[v.nchips - 1] + 24'(v.size[v.nchips - 1]) - 24'd1});
    stray_en = 1'b0;
    idle(3);
  endtask

  initial begin
    //          hlen  id    ex gm n  s0      s1      s2     p0  p1      p2 bad  trunc  ack st att er bk wr      r0 r1      r2
    tbl[0]  = mk(32'h40, 0,    0, 1, 1, 'h2000, 0,      0,     0,  0,      0, -1,  0,     0, 0, 1, 0, 1, 'h2000, 0, 0,      0);
    tbl[1]  = mk(32'h40, 'h13, 1, 1, 3, 'h1000, 'h0801, 'h400, 0,  0,      0, -1,  0,     0, 0, 1, 0, 3, 'h1C01, 0, 'h2000, 'h4000);
    tbl[2]  = mk(32'h40, 0,    0, 1, 1, 'h100,  0,      0,     0,  0,      0, 3,   0,     0, 0, 0, 1, 0, 0,      0, 0,      0);
    tbl[3]  = mk(32'h50, 'h20, 1, 0, 2, 'h800,  'h800,  0,     16, 16,     0, -1,  0,     0, 0, 1, 0, 2, 'h1000, 0, 'h2000, 0);
    tbl[4]  = mk(32'h40, 0,    0, 1, 1, 'h100,  0,      0,     0,  0,      0, -1,  'h47,  0, 0, 0, 1, 0, 0,      0, 0,      0);
    tbl[5]  = mk(32'h40, 5,    1, 1, 3, 0,      0,      'h100, 0,  4,      0, -1,  0,     0, 0, 1, 0, 3, 'h100,  0, 0,      0);
    tbl[6]  = mk(32'h40, 0,    0, 1, 1, 'h100,  0,      0,     'hFFFF, 0,  0, -1,  0,     0, 0, 0, 1, 0, 0,      0, 0,      0);
    tbl[7]  = mk(32'h40, 0,    0, 1, 2, 'h100,  'hF000, 0,     0,  0,      0, -1,  'h180, 0, 0, 0, 1, 2, 'h100,  0, 'h2000, 0);
    tbl[8]  = mk(32'h40, 0,    0, 1, 1, 'h400,  0,      0,     0,  0,      0, -1,  'h150, 0, 0, 1, 0, 1, 'h100,  0, 0,      0);
    tbl[9]  = mk(32'h40, 0,    0, 1, 1, 'h200,  0,      0,     0,  0,      0, -1,  0,     5, 1, 1, 0, 1, 'h200,  0, 0,      0);
    tbl[10] = mk(32'h20, 'hA5, 0, 0, 1, 'h100,  0,      0,     0,  0,      0, -1,  0,     0, 0, 1, 0, 1, 'h100,  0, 0,      0);
    tbl[11] = mk(32'h40, 0,    0, 1, 1, 'h100,  0,      0,     0,  0,      0, -1,  'h20,  0, 0, 0, 1, 0, 0,      0, 0,      0);

    idle(3);
    reset = 1'b0;
    chk_zero("reset");
    idle(2);

    for (int i = 0; i < 12; i++) run_entry(i);

    // Reset in the middle of a payload, then a fresh download.
    build(tbl[3]);
    ack_delay = 0;
    ioctl_download = 1'b1;
    idle(1);
    for (int i = 0; i < 16'h50 + 15; i++) send_byte(file_q[i]);
    send_byte(file_q[16'h50 + 15]);
    chk("rs_bank_pulse", {15'd0, cart_bank_wr, cart_bank_size}, {16'd1, 16'h0800});
    chk("rs_hdr_nowait", {31'd0, ioctl_wait}, 32'd0);
    idle(1);
    chk("rs_bank_single", {31'd0, cart_bank_wr}, 32'd0);
    ioctl_wr = 1'b1; ioctl_data = file_q[16'h60];
    @(posedge clk32); #1;
    ioctl_wr = 1'b0;
    chk("rs_first_write", {6'd0, mem_wr, ioctl_wait, mem_addr}, {8'h03, ROM_BASE});
    chk("rs_first_data", {24'd0, mem_data}, {24'd0, file_q[16'h60]});
    for (int i = 16'h61; i < 16'h80; i++) send_byte(file_q[i]);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk_zero("mid_reset");
    idle(5);
    chk("rs_no_restart", {31'd0, cart_loading}, 32'd0);
    ioctl_download = 1'b0;
    idle(3);
    run_entry(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
